// File: rtl/gba_dma_pkg.sv
// rtl/gba_dma_pkg.sv - shared timing-mode constants and scheduler state type
package gba_dma_pkg;

  localparam logic [1:0] TIMING_IMMEDIATE = 2'd0;
  localparam logic [1:0] TIMING_VBLANK    = 2'd1;
  localparam logic [1:0] TIMING_HBLANK    = 2'd2;
  localparam logic [1:0] TIMING_SPECIAL   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/gba_dma_prio_enc.sv
// rtl/gba_dma_prio_enc.sv - fixed-priority select, lowest index wins
module gba_dma_prio_enc (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        idx   = i[1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gba_dma_trigger_sched.sv
// rtl/gba_dma_trigger_sched.sv - DMA trigger capture, pending flags and request handshake
module gba_dma_trigger_sched
  import gba_dma_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CAPTURE_CH = 3
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [2*NCH-1:0] ch_timing,
  input  logic             hblank_trigger,
  input  logic             vblank_trigger,
  input  logic             videodma_start,
  input  logic             videodma_stop,
  input  logic [1:0]       sound_fifo_req,
  output logic             dma_req,
  output logic [1:0]       dma_ch,
  input  logic             dma_ack,
  input  logic             dma_done,
  output logic [NCH-1:0]   pending,
  output logic             busy,
  output logic             capture_stop
);

  state_t         state;
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] pending_next;
  logic           stop_ev;
  logic           ack_ok;
  logic [1:0]     grant_idx;
  logic           grant_valid;

  gba_dma_prio_enc u_prio (
    .req   (pending),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  assign stop_ev = videodma_stop && (ch_timing[2*CAPTURE_CH +: 2] == TIMING_SPECIAL);
  assign ack_ok  = (state == REQ) && dma_ack && ch_enable[dma_ch];

  // A set event outranks the ack/stop clear; a disabled channel always clears.
  always_comb begin
    logic [1:0] tm;
    logic       ev;
    logic       keep;
    pending_next = '0;
    tm   = 2'd0;
    ev   = 1'b0;
    keep = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      tm = ch_timing[2*n +: 2];
      case (tm)
        TIMING_IMMEDIATE: ev = !en_q[n];
        TIMING_VBLANK:    ev = vblank_trigger;
        TIMING_HBLANK:    ev = hblank_trigger;
        default:          ev = (n == 1 && sound_fifo_req[0]) ||
                               (n == 2 && sound_fifo_req[1]) ||
                               (n == CAPTURE_CH && n != 0 && videodma_start);
      endcase
      keep = pending[n] && !(ack_ok && dma_ch == n[1:0]) && !(stop_ev && n == CAPTURE_CH);
      pending_next[n] = ch_enable[n] && (keep || ev);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state        <= IDLE;
      dma_req      <= 1'b0;
      dma_ch       <= 2'd0;
      busy         <= 1'b0;
      capture_stop <= 1'b0;
      pending      <= '0;
      en_q         <= '0;
    end else begin
      en_q         <= ch_enable;
      pending      <= pending_next;
      capture_stop <= stop_ev;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            dma_ch  <= grant_idx;
            dma_req <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Channel disabled under us: withdraw without waiting for an ack.
          if (!ch_enable[dma_ch]) begin
            dma_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (dma_ack) begin
            dma_req <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (dma_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          dma_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
